// File: rtl/cpu_pkg.sv
// Shared decode constants, FSM state type and ALU for the multicycle core.
package cpu_pkg;

    localparam logic [1:0] FORM_IMM  = 2'd0;
    localparam logic [1:0] FORM_REG  = 2'd1;
    localparam logic [1:0] FORM_BR   = 2'd2;
    localparam logic [1:0] FORM_HALT = 2'd3;

    localparam logic [5:0] OP_CMP_MASK  = 6'b111100;
    localparam logic [5:0] OP_CMP_VAL   = 6'b001100;
    localparam logic [5:0] OP_MEM_MASK  = 6'b110000;
    localparam logic [5:0] OP_LOAD_VAL  = 6'b010000;
    localparam logic [5:0] OP_STORE_VAL = 6'b100000;

    localparam int LINK_BIT   = 29;
    localparam int ALWAYS_BIT = 28;
    localparam int FORM_LSB   = 30;
    localparam int OP_LSB     = 24;
    localparam int RD_LSB     = 20;
    localparam int RA_LSB     = 16;
    localparam int RB_LSB     = 12;

    localparam logic [3:0] LINK_REG = 4'd15;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // aluops 12..15 are the compare family; only bit 0 of their result matters.
    function automatic logic [31:0] alu_f(input logic [3:0] aluop,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (aluop)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd12:   r = {31'b0, a == b};
            4'd13:   r = {31'b0, a < b};
            4'd14:   r = {31'b0, $signed(a) < $signed(b)};
            4'd15:   r = {31'b0, a != b};
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_mc_if.sv
// Memory port of the multicycle core: request/acknowledge with wait states.
interface cpu_mc_if #(
    parameter int ADDR_W = 30
);
    // mem_req rises with mem_we/mem_addr/mem_wdata and holds them steady until
    // the rising edge where mem_req && mem_ack; mem_rdata is taken at that edge.
    // mem_ack seen while mem_req is low means nothing.
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_regfile.sv
// 16 x 32 general register file: two combinational reads, one write, async clear.
module cpu_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [3:0]  raddr_b_i,
    output logic [31:0] rdata_b_o
);
    logic [31:0] regs_q [16];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
endmodule

// File: rtl/cpu_mc.sv
// Multicycle core: BOOT/FETCH/EXEC/MEM/HALT sequencing over a req/ack memory port.
module cpu_mc
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 30,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                NCR      = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    cpu_mc_if.master mem,
    output logic     halted,
    output state_e   state_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [31:0]       ir_q, ir_d, wdata_q, wdata_d;
    logic              req_q, req_d, we_q, we_d, halted_q, halted_d;
    logic [NCR-1:0]    cr_q, cr_d;

    logic [1:0]  form;
    logic [5:0]  op;
    logic [3:0]  rd, ra, rb;
    logic        is_cmp, is_load, is_store, taken;
    logic [15:0] cr_all;
    logic [31:0] rf_rdata_a, rf_rdata_b, alu_b, alu_out, rf_wdata;
    logic [3:0]  rf_raddr_b, rf_waddr;
    logic        rf_we;
    logic [ADDR_W-1:0] pc_inc, br_tgt;

    assign form     = ir_q[FORM_LSB +: 2];
    assign op       = ir_q[OP_LSB +: 6];
    assign rd       = ir_q[RD_LSB +: 4];
    assign ra       = ir_q[RA_LSB +: 4];
    assign rb       = ir_q[RB_LSB +: 4];
    assign is_cmp   = (op & OP_CMP_MASK) == OP_CMP_VAL;
    assign is_load  = (op & OP_MEM_MASK) == OP_LOAD_VAL;
    assign is_store = (op & OP_MEM_MASK) == OP_STORE_VAL;

    // Port B serves store data, so a register-form store addresses with ra alone.
    assign rf_raddr_b = is_store ? rd : rb;
    assign alu_b      = (form == FORM_IMM) ? {16'b0, ir_q[15:0]} :
                        (is_store ? 32'b0 : rf_rdata_b);
    assign alu_out    = alu_f(op[3:0], rf_rdata_a, alu_b);

    assign cr_all = 16'(cr_q);
    assign taken  = ir_q[ALWAYS_BIT] | cr_all[ir_q[27:24]];
    assign pc_inc = pc_q + ADDR_W'(1);
    assign br_tgt = ADDR_W'(32'(pc_q) + {{8{ir_q[23]}}, ir_q[23:0]});

    cpu_regfile u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (ra),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (rf_raddr_b),
        .rdata_b_o (rf_rdata_b)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        wdata_d  = wdata_q;
        req_d    = req_q;
        we_d     = we_q;
        halted_d = halted_q;
        cr_d     = cr_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_out;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_q;
            end
            ST_FETCH: begin
                if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata;
                    req_d   = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (form == FORM_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    req_d    = 1'b0;
                end else if (form == FORM_BR) begin
                    pc_d    = taken ? br_tgt : pc_inc;
                    addr_d  = taken ? br_tgt : pc_inc;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                    if (ir_q[LINK_BIT]) begin
                        rf_we    = 1'b1;
                        rf_waddr = LINK_REG;
                        rf_wdata = 32'(pc_inc);
                    end
                end else if (is_load || is_store) begin
                    addr_d  = alu_out[ADDR_W-1:0];
                    we_d    = is_store;
                    req_d   = 1'b1;
                    state_d = ST_MEM;
                    if (is_store) wdata_d = rf_rdata_b;
                end else begin
                    if (is_cmp) begin
                        for (int i = 0; i < NCR; i++) begin
                            if (rd == 4'(i)) cr_d[i] = alu_out[0];
                        end
                    end else begin
                        rf_we = 1'b1;
                    end
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem.mem_rdata;
                    end
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    we_d    = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            ir_q     <= '0;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
            cr_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            halted_q <= halted_d;
            cr_q     <= cr_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign halted        = halted_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_cpu_mc.sv
// Directed program run against a wait-state memory model with an access-trace scoreboard.
module tb_cpu_mc;
    import cpu_pkg::*;

    localparam int AW = 8;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_CMPEQ = 6'b001100;
    localparam logic [5:0] OP_LD    = 6'b010000;
    localparam logic [5:0] OP_ST    = 6'b100000;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   halted;
    state_e dbg_state;

    cpu_mc_if #(.ADDR_W(AW)) bus ();

    cpu_mc #(.ADDR_W(AW), .RESET_PC(8'h10), .NCR(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem     (bus),
        .halted  (halted),
        .state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] mem [256];
    logic [40:0] exp_q[$];
    logic stall_all = 1'b0;
    logic ack_force = 1'b0;
    int wait_cnt = 0;
    logic prev_stall = 1'b0;
    logic [40:0] prev_acc;
    int first_fetch_cyc = -1;
    int store40_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [3:0] rd, logic [3:0] ra, logic [15:0] imm);
        return {2'b00, op, rd, ra, imm};
    endfunction

    function automatic logic [31:0] enc_r(logic [5:0] op, logic [3:0] rd, logic [3:0] ra, logic [3:0] rb);
        return {2'b01, op, rd, ra, rb, 12'b0};
    endfunction

    function automatic logic [31:0] enc_b(logic lnk, logic alw, logic [3:0] crs, logic [23:0] imm);
        return {2'b10, lnk, alw, crs, imm};
    endfunction

    function automatic int wait_for(logic [7:0] a, logic we);
        if (!we && a == 8'h80) return 3;
        if (!we && a == 8'h13) return 1;
        if (we && a == 8'h42)  return 2;
        return 0;
    endfunction

    task automatic load_program();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = enc_i(OP_ADD, 4'd1, 4'd0, 16'd5);
        mem[8'h11] = enc_i(OP_ST, 4'd1, 4'd0, 16'h40);
        mem[8'h12] = enc_i(OP_LD, 4'd2, 4'd0, 16'h80);
        mem[8'h13] = enc_i(OP_ST, 4'd2, 4'd0, 16'h41);
        mem[8'h14] = enc_r(OP_SUB, 4'd3, 4'd2, 4'd1);
        mem[8'h15] = enc_i(OP_ST, 4'd3, 4'd0, 16'h42);
        mem[8'h16] = enc_i(OP_CMPEQ, 4'd2, 4'd1, 16'd5);
        mem[8'h17] = enc_b(1'b0, 1'b1, 4'd0, 24'hFFFFF1);
        mem[8'h08] = enc_b(1'b0, 1'b0, 4'd2, 24'hFFFFFF);
        mem[8'h07] = enc_i(OP_CMPEQ, 4'd2, 4'd1, 16'd6);
        mem[8'h09] = enc_b(1'b0, 1'b1, 4'd0, 24'h000017);
        mem[8'h20] = enc_b(1'b1, 1'b1, 4'd0, 24'h000010);
        mem[8'h30] = enc_i(OP_ST, 4'd15, 4'd0, 16'h43);
        mem[8'h31] = enc_b(1'b1, 1'b0, 4'd5, 24'h000040);
        mem[8'h32] = enc_i(OP_ST, 4'd15, 4'd0, 16'h44);
        mem[8'h33] = 32'hC000_0000;
        mem[8'h80] = 32'h1234_5678;
    endtask

    task automatic push_rd(input logic [7:0] a);
        exp_q.push_back({1'b0, a, 32'h0});
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic push_trace();
        push_rd(8'h10); push_rd(8'h11); push_wr(8'h40, 32'd5);
        push_rd(8'h12); push_rd(8'h80); push_rd(8'h13); push_wr(8'h41, 32'h1234_5678);
        push_rd(8'h14); push_rd(8'h15); push_wr(8'h42, 32'h1234_5673);
        push_rd(8'h16); push_rd(8'h17); push_rd(8'h08); push_rd(8'h07);
        push_rd(8'h08); push_rd(8'h09); push_rd(8'h20); push_rd(8'h30);
        push_wr(8'h43, 32'h21); push_rd(8'h31); push_rd(8'h32);
        push_wr(8'h44, 32'h32); push_rd(8'h33);
    endtask

    // Memory model and monitor: ack for the coming edge is decided here.
    always @(negedge clk) begin : monitor
        logic [40:0] cur;
        logic [40:0] e;
        bus.mem_rdata = mem[bus.mem_addr];
        if (bus.mem_req) begin
            cur = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0};
            if (prev_stall) check("hold_stable", 64'(cur), 64'(prev_acc));
            bus.mem_ack = !stall_all && (wait_cnt >= wait_for(bus.mem_addr, bus.mem_we));
            if (bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got we=%0b addr=%0h required none", bus.mem_we, bus.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_we_addr", 64'({bus.mem_we, bus.mem_addr}), 64'(e[40:32]));
                    if (e[40]) check("acc_wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
                end
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                if (!bus.mem_we && bus.mem_addr == 8'h10 && first_fetch_cyc < 0) first_fetch_cyc = cyc;
                if (bus.mem_we && bus.mem_addr == 8'h40 && store40_cyc < 0) store40_cyc = cyc;
                wait_cnt = 0;
                prev_stall = 1'b0;
            end else begin
                wait_cnt++;
                prev_stall = 1'b1;
                prev_acc = cur;
            end
        end else begin
            bus.mem_ack = ack_force;
            wait_cnt = 0;
            prev_stall = 1'b0;
        end
    end

    task automatic wait_halt(input string name);
        for (int i = 0; i < 600 && !halted; i++) @(negedge clk);
        check(name, 64'(halted), 64'd1);
        check({name, "_trace_done"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        load_program();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 64'(bus.mem_req), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_BOOT));

        push_trace();
        #1 rst_n = 1'b1;
        #1 check("boot_no_req", 64'(bus.mem_req), 64'd0);
        @(negedge clk);
        check("first_req", 64'(bus.mem_req), 64'd1);
        check("first_addr", 64'(bus.mem_addr), 64'h10);

        wait_halt("halt_run1");
        check("store40_latency", 64'(store40_cyc - first_fetch_cyc), 64'd4);

        ack_force = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_no_req", 64'(bus.mem_req), 64'd0);
            check("halt_held", 64'(halted), 64'd1);
        end
        ack_force = 1'b0;

        #2 rst_n = 1'b0;
        #1 check("rst_clears_halted", 64'(halted), 64'd0);
        check("rst_state_boot", 64'(dbg_state), 64'(ST_BOOT));

        stall_all = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_req", 64'(bus.mem_req), 64'd1);
        check("stall_addr", 64'(bus.mem_addr), 64'h10);
        check("stall_state", 64'(dbg_state), 64'(ST_FETCH));
        #2 rst_n = 1'b0;
        #1 check("abort_req_drop", 64'(bus.mem_req), 64'd0);

        @(negedge clk);
        stall_all = 1'b0;
        push_trace();
        #1 rst_n = 1'b1;
        wait_halt("halt_run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
